// File: rtl/bus_pkg.sv
// Shared bus types: packet layout, kinds, and responder FSM states.
// Imported by the memory endpoint and its testbench.
package bus_pkg;

  typedef logic [3:0]  BusID;
  typedef logic [31:0] memory_address_t;
  typedef logic [63:0] bus_packet_payload_t;

  typedef enum logic [1:0] {
    bus_read_data     = 2'd0,
    bus_write_data    = 2'd1,
    bus_read_response = 2'd2
  } bus_kind_t;

  typedef struct packed {
    bus_kind_t           kind;
    BusID                source;
    memory_address_t     address;
    bus_packet_payload_t payload;
  } BusPacket;

  localparam int PAYLOAD_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE, EXEC, WAIT, RESPOND
  } resp_state_t;

endpackage

// File: rtl/memory_responder_ram.sv
// Single-port synchronous RAM, one read or write per cycle.
// Ports: clk, reset (clears read register only), en, we, addr, wdata, rdata.
module memory_responder_ram
  import bus_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  bus_packet_payload_t wdata,
  output bus_packet_payload_t rdata
);

  bus_packet_payload_t mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Read register holds its word until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_responder.sv
// Memory endpoint: consumes read/write requests, returns read responses.
// Ports: request slot (busy/data/accept), response slot (busy/send/data),
// error_illegal pulse, idle status.
module memory_responder
  import bus_pkg::*;
#(
  parameter int MEM_WORDS    = 1024,
  parameter int READ_LATENCY = 2,
  parameter int RESPONDER_ID = 0
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     request_busy,
  input  BusPacket request_data,
  output logic     request_accept,
  input  logic     response_busy,
  output logic     response_send,
  output BusPacket response_data,
  output logic     error_illegal,
  output logic     idle
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  resp_state_t         state, state_n;
  BusPacket            req, req_n;
  logic [3:0]          cnt, cnt_n;
  logic                accept_n, send_n, err_n;
  BusID                src, src_n;
  bus_kind_t           kind_r, kind_n;
  logic                ram_en, ram_we;
  logic [AW-1:0]       ram_addr;
  bus_packet_payload_t ram_q;
  logic                unused_bits;

  assign ram_addr = req.address[AW+2:3];
  assign unused_bits = ^{req.address[31:AW+3],
                         req.address[2:0], RESPONDER_ID};

  memory_responder_ram #(
    .MEM_WORDS(MEM_WORDS)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(req.payload),
    .rdata(ram_q)
  );

  // Payload comes straight from the RAM read register, which
  // only changes on a read, so it stays stable while stalled.
  assign response_data = '{
    kind:    kind_r,
    source:  src,
    address: '0,
    payload: ram_q
  };

  always_comb begin
    state_n  = state;
    req_n    = req;
    cnt_n    = cnt;
    src_n    = src;
    kind_n   = kind_r;
    accept_n = 1'b0;
    send_n   = 1'b0;
    err_n    = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    unique case (state)
      IDLE: begin
        if (request_busy) begin
          req_n    = request_data;
          accept_n = 1'b1;
          state_n  = EXEC;
        end
      end
      EXEC: begin
        unique case (1'b1)
          (req.kind == bus_write_data): begin
            ram_en  = 1'b1;
            ram_we  = 1'b1;
            state_n = IDLE;
          end
          (req.kind == bus_read_data): begin
            ram_en = 1'b1;
            cnt_n  = LAT_M1;
            src_n  = req.source;
            kind_n = bus_read_response;
            if (READ_LATENCY == 1) begin
              state_n = RESPOND;
              send_n  = !response_busy;
            end else begin
              state_n = WAIT;
            end
          end
          default: begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        endcase
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt_n == 4'd0) begin
          state_n = RESPOND;
          send_n  = !response_busy;
        end
      end
      RESPOND: begin
        // send is high in a RESPOND cycle; leave right after it
        if (response_send) state_n = IDLE;
        else               send_n  = !response_busy;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      req            <= '0;
      cnt            <= '0;
      src            <= '0;
      kind_r         <= bus_read_data;
      request_accept <= 1'b0;
      response_send  <= 1'b0;
      error_illegal  <= 1'b0;
      idle           <= 1'b1;
    end else begin
      state          <= state_n;
      req            <= req_n;
      cnt            <= cnt_n;
      src            <= src_n;
      kind_r         <= kind_n;
      request_accept <= accept_n;
      response_send  <= send_n;
      error_illegal  <= err_n;
      idle           <= (state_n == IDLE);
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Randomized bench for memory_responder against a word-array model.
// Covers latency, backpressure, wrap, illegal kinds and reset.
module tb_memory_responder;
  import bus_pkg::*;

  localparam int MEM_WORDS = 1024;
  localparam int LAT       = 2;

  logic     clk = 1'b0;
  logic     reset;
  logic     request_busy;
  BusPacket request_data;
  logic     request_accept;
  logic     response_busy;
  logic     response_send;
  BusPacket response_data;
  logic     error_illegal;
  logic     idle;

  always #5 clk = ~clk;

  memory_responder #(
    .MEM_WORDS   (MEM_WORDS),
    .READ_LATENCY(LAT),
    .RESPONDER_ID(0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .request_busy  (request_busy),
    .request_data  (request_data),
    .request_accept(request_accept),
    .response_busy (response_busy),
    .response_send (response_send),
    .response_data (response_data),
    .error_illegal (error_illegal),
    .idle          (idle)
  );

  bus_packet_payload_t model [int];
  memory_address_t     pool [$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input memory_address_t a);
    return int'((a / PAYLOAD_BYTES) % MEM_WORDS);
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!idle && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!idle) chk("idle_timeout", idle, 1);
  endtask

  task automatic issue(input bus_kind_t k, input BusID s,
                       input memory_address_t a,
                       input bus_packet_payload_t p);
    wait_idle();
    request_data = '{kind: k, source: s, address: a, payload: p};
    request_busy = 1'b1;
    @(negedge clk);
    chk("accept_e1", request_accept, 1);
    request_busy = 1'b0;
  endtask

  task automatic do_write(input BusID s, input memory_address_t a,
                          input bus_packet_payload_t p);
    issue(bus_write_data, s, a, p);
    model[idx_of(a)] = p;
    @(negedge clk);
    chk("wr_idle_e2", idle, 1);
    chk("wr_no_err", error_illegal, 0);
  endtask

  task automatic do_read(input BusID s, input memory_address_t a);
    int lat = 1;
    issue(bus_read_data, s, a, '0);
    while (!response_send && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rd_latency", lat, 1 + LAT);
    chk("rd_kind", response_data.kind, bus_read_response);
    chk("rd_source", response_data.source, s);
    chk("rd_addr", response_data.address, 0);
    if (model.exists(idx_of(a)))
      chk("rd_payload", response_data.payload, model[idx_of(a)]);
  endtask

  task automatic count_sends(input int cycles, output int sends);
    sends = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (response_send) sends++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    BusPacket ref_pkt;
    int sends, accs, cyc, last;
    int gaps [3];
    memory_address_t a;
    bus_packet_payload_t pl;
    memory_address_t bb [3];
    bus_packet_payload_t bp [3];

    reset         = 1'b1;
    request_busy  = 1'b0;
    request_data  = '0;
    response_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_accept", request_accept, 0);
    chk("rst_send", response_send, 0);
    chk("rst_err", error_illegal, 0);
    chk("rst_data", response_data, 0);
    chk("rst_idle", idle, 1);
    reset = 1'b0;
    @(negedge clk);

    // write then read
    do_write(4'd3, 32'h40, 64'hDEADBEEF_CAFEF00D);
    do_read(4'd3, 32'h40);

    // backpressure with a second request waiting
    response_busy = 1'b1;
    issue(bus_read_data, 4'd5, 32'h40, '0);
    request_data = '{kind: bus_write_data, source: 4'd6,
                     address: 32'h48, payload: 64'h1111_2222_3333_4444};
    request_busy = 1'b1;
    sends = 0;
    accs  = 0;
    ref_pkt = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (response_send) sends++;
      if (request_accept) accs++;
      if (i == 1) ref_pkt = response_data;
      if (i > 1) chk("bp_stable", response_data, ref_pkt);
    end
    chk("bp_no_send", sends, 0);
    chk("bp_no_accept", accs, 0);
    chk("bp_payload", ref_pkt.payload, model[idx_of(32'h40)]);
    chk("bp_source", ref_pkt.source, 5);
    response_busy = 1'b0;
    @(negedge clk);
    chk("bp_send_after", response_send, 1);
    cyc = 0;
    while (!request_accept && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_pending_accept", request_accept, 1);
    request_busy = 1'b0;
    model[idx_of(32'h48)] = 64'h1111_2222_3333_4444;
    do_read(4'd6, 32'h48);

    // back-to-back writes, request_busy held
    bb[0] = 32'h0;
    bb[1] = 32'h8;
    bb[2] = 32'h10;
    for (int i = 0; i < 3; i++)
      bp[i] = {$urandom(), $urandom()};
    wait_idle();
    request_data = '{kind: bus_write_data, source: 4'd1,
                     address: bb[0], payload: bp[0]};
    request_busy = 1'b1;
    cyc  = 0;
    last = 0;
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      do begin
        @(negedge clk);
        cyc++;
        n++;
      end while (!request_accept && n < 10);
      gaps[i] = cyc - last;
      last = cyc;
      model[idx_of(bb[i])] = bp[i];
      if (i < 2)
        request_data = '{kind: bus_write_data, source: 4'd1,
                         address: bb[i+1], payload: bp[i+1]};
      else
        request_busy = 1'b0;
    end
    chk("b2b_first", gaps[0], 1);
    chk("b2b_gap1", gaps[1], 2);
    chk("b2b_gap2", gaps[2], 2);
    for (int i = 0; i < 3; i++) do_read(4'd2, bb[i]);

    // address wrap
    do_write(4'd4, 32'h2000, 64'h0123_4567_89AB_CDEF);
    do_read(4'd4, 32'h0);

    // illegal kinds
    issue(bus_read_response, 4'd7, 32'h40, 64'hBAD0_BAD0_BAD0_BAD0);
    @(negedge clk);
    chk("ill_err", error_illegal, 1);
    @(negedge clk);
    chk("ill_err_pulse", error_illegal, 0);
    count_sends(6, sends);
    chk("ill_no_send", sends, 0);
    issue(bus_kind_t'(2'd3), 4'd7, 32'h40, 64'hBAD1_BAD1_BAD1_BAD1);
    @(negedge clk);
    chk("ill3_err", error_illegal, 1);
    do_read(4'd7, 32'h40);

    // reset during WAIT
    do_write(4'd8, 32'h100, 64'hAAAA_5555_AAAA_5555);
    issue(bus_read_data, 4'd8, 32'h100, '0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rr_accept", request_accept, 0);
    chk("rr_send", response_send, 0);
    chk("rr_data", response_data, 0);
    chk("rr_idle", idle, 1);
    @(negedge clk);
    reset = 1'b0;
    count_sends(10, sends);
    chk("rr_no_send", sends, 0);
    do_read(4'd8, 32'h100);

    // reset during write EXEC: write is dropped
    issue(bus_write_data, 4'd9, 32'h100, 64'hFFFF_0000_FFFF_0000);
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_read(4'd9, 32'h100);

    // randomized traffic
    for (int i = 0; i < 6; i++) begin
      a  = $urandom() & 32'h0000_1FF8;
      pl = {$urandom(), $urandom()};
      do_write(4'($urandom_range(15)), a, pl);
      pool.push_back(a);
    end
    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(9);
      a = pool[$urandom_range(pool.size() - 1)];
      a = a ^ ($urandom() << 13) ^ 32'($urandom_range(7));
      if (r == 0) begin
        issue(bus_read_response, 4'($urandom_range(15)), a, '1);
        @(negedge clk);
        chk("rnd_ill", error_illegal, 1);
      end else if (r < 5) begin
        do_write(4'($urandom_range(15)), a, {$urandom(), $urandom()});
      end else begin
        do_read(4'($urandom_range(15)), a);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
